mem_cmd_master: RTL

- Initiator-side sequencer for the button-style memory interface of memory_FPGA: a 16-bit switch bus, an address-latch strobe, a write strobe and a 16-bit read-back bus.
- Accepts word commands (WRITE, READ, FILL) over a valid/ready handshake and issues the matching strobe and data sequences.
- Returns read data with a one-cycle valid pulse.
- Sits between the control/debug logic and the memory block; it replaces the manual switch and button operation.

---
 rtl/mem_cmd_master.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_cmd_master.sv
// Command sequencer that drives the button-style memory port (switch bus,
// address strobe, write strobe) and captures read-back data.
module mem_cmd_master #(
   parameter int DATA_W    = 16,
   parameter int LEN_W     = 8,
   parameter int READ_WAIT = 2
) (
   input  logic              clk,
   input  logic              initialise,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic [DATA_W-1:0] mem_sw,
   output logic              mem_btn_addr,
   output logic              mem_btn_write,
   input  logic [DATA_W-1:0] mem_out,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              done,
   output logic              busy
);

   localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_FILL  = 2'b10;
   localparam logic [1:0] OP_NOP   = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      WR,
      RWAIT
   } state_t;

   state_t            state;
   logic [1:0]        op;
   logic [DATA_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_data;
   logic [LEN_W-1:0]  remain;
   logic [CW-1:0]     wait_cnt;

   // The capture happens on the edge that ends the last wait cycle, so the
   // cycle carrying rd_valid/done is already IDLE and can accept a command.
   always_ff @(posedge clk) begin
      if (initialise) begin
         state         <= IDLE;
         op            <= OP_WRITE;
         cur_addr      <= '0;
         cur_data      <= '0;
         remain        <= '0;
         wait_cnt      <= '0;
         cmd_ready     <= 1'b1;
         mem_sw        <= '0;
         mem_btn_addr  <= 1'b0;
         mem_btn_write <= 1'b0;
         rd_data       <= '0;
         rd_valid      <= 1'b0;
         done          <= 1'b0;
         busy          <= 1'b0;
      end else begin
         mem_btn_addr  <= 1'b0;
         mem_btn_write <= 1'b0;
         rd_valid      <= 1'b0;
         done          <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  if (cmd_op == OP_NOP ||
                      (cmd_op == OP_FILL && cmd_len == '0)) begin
                     done <= 1'b1;
                  end else begin
                     op           <= cmd_op;
                     cur_addr     <= cmd_addr;
                     cur_data     <= cmd_data;
                     remain       <= cmd_len;
                     mem_sw       <= cmd_addr;
                     mem_btn_addr <= 1'b1;
                     cmd_ready    <= 1'b0;
                     busy         <= 1'b1;
                     state        <= ADDR;
                  end
               end
            end
            ADDR: begin
               if (op == OP_READ) begin
                  wait_cnt <= CW'(READ_WAIT - 1);
                  state    <= RWAIT;
               end else begin
                  mem_sw        <= cur_data;
                  mem_btn_write <= 1'b1;
                  state         <= WR;
               end
            end
            WR: begin
               if (op == OP_WRITE || remain == LEN_W'(1)) begin
                  done      <= 1'b1;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  cur_addr     <= cur_addr + 1'b1;
                  cur_data     <= cur_data + 1'b1;
                  remain       <= remain - 1'b1;
                  mem_sw       <= cur_addr + 1'b1;
                  mem_btn_addr <= 1'b1;
                  state        <= ADDR;
               end
            end
            RWAIT: begin
               if (wait_cnt == '0) begin
                  rd_data   <= mem_out;
                  rd_valid  <= 1'b1;
                  done      <= 1'b1;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
